// File: rtl/mem_bus_responder.sv
// Memory-side responder for the core's byte strobes: a mirrored byte RAM plus a
// 16-byte I/O window holding a TX FIFO, a status register and an RX holding register.
module mem_bus_responder #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned TX_DEPTH = 4,
  parameter logic [15:0] IO_BASE  = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] abus,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  // Handshakes: a byte moves on any posedge where its valid and ready are both high;
  // valid never waits on ready, and ready (rx_ready here) depends only on register state.

  localparam int unsigned IDX_W = $clog2(TX_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(TX_DEPTH);

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h1;
  localparam logic [3:0] OFF_RXDATA = 4'h2;

  // ---------------- decode ----------------
  logic              io_sel;
  logic [3:0]        io_off;
  logic [ADDR_W-1:0] ram_addr;
  logic              rd_en;

  assign io_sel   = (abus[15:4] == IO_BASE[15:4]);
  assign io_off   = abus[3:0];
  assign ram_addr = abus[ADDR_W-1:0];
  // A simultaneous read+write is treated as a write only.
  assign rd_en    = mem_read && !mem_write;

  // ---------------- state ----------------
  logic [7:0]       mem_q [2**ADDR_W];
  logic [7:0]       buf_q [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count_q,  count_d;
  logic             ovf_q,    ovf_d;
  logic             rx_full_q, rx_full_d;
  logic [7:0]       rx_buf_q,  rx_buf_d;

  logic tx_full, tx_empty;
  logic push_req, push_acc, pop;
  logic ram_we, status_wr;
  logic capture, cpu_pop;
  logic [7:0] status_byte;
  logic [7:0] rd_data;

  assign tx_full  = (count_q == FULL_CNT);
  assign tx_empty = (count_q == '0);
  assign tx_valid = !tx_empty;
  assign tx_data  = buf_q[rd_ptr_q[IDX_W-1:0]];
  assign rx_ready = !rx_full_q;

  assign ram_we    = mem_write && !io_sel;
  assign push_req  = mem_write && io_sel && (io_off == OFF_TXDATA);
  assign status_wr = mem_write && io_sel && (io_off == OFF_STATUS);
  assign pop       = tx_valid && tx_ready;
  // A push at full survives only if the head leaves on the same edge.
  assign push_acc  = push_req && (!tx_full || pop);
  assign capture   = rx_valid && rx_ready;
  assign cpu_pop   = rd_en && io_sel && (io_off == OFF_RXDATA);

  assign status_byte = {4'b0000, ovf_q, rx_full_q, tx_empty, tx_full};

  // ---------------- next state ----------------
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    rx_full_d = rx_full_q;
    rx_buf_d  = rx_buf_q;

    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push_acc, pop})
      2'b10:   count_d = count_q + PTR_W'(1);
      2'b01:   count_d = count_q - PTR_W'(1);
      default: count_d = count_q;
    endcase

    if (status_wr)
      ovf_d = 1'b0;
    else if (push_req && tx_full && !pop)
      ovf_d = 1'b1;

    if (cpu_pop) begin
      rx_full_d = 1'b0;
    end else if (capture) begin
      rx_full_d = 1'b1;
      rx_buf_d  = rx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rx_full_q <= 1'b0;
      rx_buf_q  <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      rx_full_q <= rx_full_d;
      rx_buf_q  <= rx_buf_d;
    end
  end

  // Storage arrays carry no reset; FIFO contents are qualified by count.
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_addr] <= din;
  end

  always_ff @(posedge clk) begin
    if (push_acc && !reset) buf_q[wr_ptr_q[IDX_W-1:0]] <= din;
  end

  // ---------------- read mux ----------------
  always_comb begin
    rd_data = 8'h00;
    if (!io_sel) begin
      rd_data = mem_q[ram_addr];
    end else begin
      case (io_off)
        OFF_STATUS: rd_data = status_byte;
        OFF_RXDATA: rd_data = rx_buf_q;
        default:    rd_data = 8'h00;
      endcase
    end
  end

  assign dout = rd_en ? rd_data : 8'hzz;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: reads and TX bytes are checked by a monitor
// against expected queues filled by the driver tasks.
module tb_mem_bus_responder;

  logic        clk;
  logic        reset;
  logic [15:0] abus;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  din;
  wire  [7:0]  dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0] rd_exp_q[$];
  logic [7:0] tx_exp_q[$];

  mem_bus_responder #(.ADDR_W(12), .TX_DEPTH(4), .IO_BASE(16'hFF00)) dut (
    .clk(clk), .reset(reset), .abus(abus), .mem_read(mem_read), .mem_write(mem_write),
    .din(din), .dout(dout), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: act=%02h req=%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor samples 3ns after each negedge, once the driver has settled the inputs.
  always @(negedge clk) begin
    #3;
    if (!reset) begin
      if (mem_read && !mem_write) begin
        if (rd_exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL dout_unexpected: act=%02h req=none at %0t", dout, $time);
        end else begin
          check("dout", dout, rd_exp_q.pop_front());
        end
      end
      if (tx_valid && tx_ready) begin
        if (tx_exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL tx_unexpected: act=%02h req=none at %0t", tx_data, $time);
        end else begin
          check("tx_data", tx_data, tx_exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    abus = a; din = d; mem_write = 1'b1; mem_read = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp);
    @(negedge clk);
    abus = a; mem_read = 1'b1; mem_write = 1'b0;
    rd_exp_q.push_back(exp);
  endtask

  task automatic rdwr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    abus = a; din = d; mem_read = 1'b1; mem_write = 1'b1;
  endtask

  task automatic set_tx_ready(input logic v);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; tx_ready = v;
  endtask

  // Idle cycle, then check a flag once inputs have settled.
  task automatic flag(input string name, input logic act_sel, input logic exp);
    logic v;
    idle();
    #3;
    v = act_sel ? tx_valid : rx_ready;
    check(name, {7'b0, v}, {7'b0, exp});
  endtask

  task automatic rx_push(input logic [7:0] d);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; rx_data = d; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    abus = 16'h0000; mem_read = 1'b0; mem_write = 1'b0; din = 8'h00;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    check("reset_tx_valid", {7'b0, tx_valid}, 8'h00);
    check("reset_rx_ready", {7'b0, rx_ready}, 8'h01);
    @(negedge clk);
    reset = 1'b0;

    // RAM write then readback
    wr(16'h0010, 8'hA5);
    wr(16'h0011, 8'h3C);
    rd(16'h0010, 8'hA5);
    rd(16'h0011, 8'h3C);
    rd(16'h1010, 8'hA5);          // mirror of 0x0010
    idle();
    rd(16'hFF01, 8'h02);          // empty FIFO after reset

    // TX fill, overflow, drain, ovf clear
    wr(16'hFF00, 8'h11);
    wr(16'hFF00, 8'h22);
    wr(16'hFF00, 8'h33);
    wr(16'hFF00, 8'h44);
    rd(16'hFF01, 8'h01);
    wr(16'hFF00, 8'h55);
    rd(16'hFF01, 8'h09);
    tx_exp_q.push_back(8'h11); tx_exp_q.push_back(8'h22);
    tx_exp_q.push_back(8'h33); tx_exp_q.push_back(8'h44);
    set_tx_ready(1'b1);
    repeat (4) idle();
    flag("tx_valid_drained", 1'b1, 1'b0);
    rd(16'hFF01, 8'h0A);
    wr(16'hFF01, 8'h00);
    rd(16'hFF01, 8'h02);
    set_tx_ready(1'b0);

    // push and pop on the same edge while full
    wr(16'hFF00, 8'hA1);
    wr(16'hFF00, 8'hA2);
    wr(16'hFF00, 8'hA3);
    wr(16'hFF00, 8'hA4);
    tx_exp_q.push_back(8'hA1); tx_exp_q.push_back(8'hA2); tx_exp_q.push_back(8'hA3);
    tx_exp_q.push_back(8'hA4); tx_exp_q.push_back(8'h66);
    @(negedge clk);
    abus = 16'hFF00; din = 8'h66; mem_write = 1'b1; mem_read = 1'b0; tx_ready = 1'b1;
    set_tx_ready(1'b0);
    rd(16'hFF01, 8'h01);          // still full, no overflow
    set_tx_ready(1'b1);
    repeat (4) idle();
    flag("tx_valid_after_66", 1'b1, 1'b0);
    set_tx_ready(1'b0);

    // RX capture and pop
    flag("rx_ready_idle", 1'b0, 1'b1);
    rx_push(8'h7E);
    #3;
    check("rx_ready_captured", {7'b0, rx_ready}, 8'h00);
    rd(16'hFF01, 8'h06);
    rd(16'hFF02, 8'h7E);
    flag("rx_ready_popped", 1'b0, 1'b1);
    rd(16'hFF01, 8'h02);
    rd(16'hFF02, 8'h7E);          // stale byte, harmless pop

    // asynchronous reset with TX queued and RX full
    wr(16'hFF00, 8'hB1);
    wr(16'hFF00, 8'hB2);
    rx_push(8'h5C);
    flag("tx_valid_queued", 1'b1, 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_tx_valid", {7'b0, tx_valid}, 8'h00);
    check("async_rx_ready", {7'b0, rx_ready}, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    rd(16'hFF01, 8'h02);
    rd(16'hFF02, 8'h00);
    rd(16'h0010, 8'hA5);
    rd(16'h0011, 8'h3C);

    // unused offsets and illegal read+write
    rd(16'hFF07, 8'h00);
    rd(16'hFF00, 8'h00);
    wr(16'hFF05, 8'h99);
    rd(16'hFF01, 8'h02);
    rdwr(16'h0020, 8'h5A);
    rd(16'h0020, 8'h5A);
    rx_push(8'h42);
    rdwr(16'hFF02, 8'h00);
    rd(16'hFF01, 8'h06);          // rx_full survived the read+write
    rd(16'hFF02, 8'h42);
    rd(16'hFF01, 8'h02);
    idle();
    repeat (2) idle();

    n_checks++;
    if (rd_exp_q.size() != 0 || tx_exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queues_drained: act=rd%0d/tx%0d req=0/0", rd_exp_q.size(), tx_exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
